// File: rtl/mpu_stream_transpose.sv
// mpu_stream_transpose
//   Streaming NxN matrix transpose between the MPU operand loader and the
//   arithmetic units. Elements arrive row-major, one per accepted cycle. A
//   completed frame is emitted row-major either transposed (mode=0) or
//   unchanged (mode=1). Two ping-pong banks let one frame fill while the
//   other drains, so sustained throughput is one element per cycle.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   mode        0 = transpose, 1 = pass-through; taken with first element
//   in_valid    input element valid
//   in_ready    a write bank is free to accept an element
//   in_data     input element (row-major)
//   in_last     producer's end-of-frame marker, checked against position
//   out_valid   a complete frame is available
//   out_ready   consumer accepts the current output element
//   out_data    output element (row-major order of the result)
//   out_last    final element of the output frame
//   frame_error sticky: in_last seen off the final position or missing on it
module mpu_stream_transpose #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         frame_error
);

  localparam int             IW   = $clog2(N);
  localparam logic [IW-1:0]  LAST = IW'(N - 1);
  localparam logic [IW-1:0]  ONE  = IW'(1);

  logic [W-1:0]  bank_q [2][N][N];
  logic [1:0]    full_q;
  logic [1:0]    mode_q;
  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] wr_row;
  logic [IW-1:0] wr_col;
  logic [IW-1:0] rd_row;
  logic [IW-1:0] rd_col;

  logic          in_fire;
  logic          out_fire;
  logic          wr_end;
  logic          rd_end;
  logic [W-1:0]  rd_elem;

  assign in_ready  = !full_q[wr_bank];
  assign in_fire   = in_valid && in_ready;
  assign wr_end    = (wr_row == LAST) && (wr_col == LAST);

  assign out_valid = full_q[rd_bank];
  assign out_fire  = out_valid && out_ready;
  assign rd_end    = (rd_row == LAST) && (rd_col == LAST);

  // Transpose is just swapped read indices; the bank is always written
  // row-major.
  always_comb begin
    rd_elem = bank_q[rd_bank][rd_col][rd_row];
    if (mode_q[rd_bank]) begin
      rd_elem = bank_q[rd_bank][rd_row][rd_col];
    end
  end

  // Gate with out_valid so an empty block never exposes stale bank contents.
  assign out_data = out_valid ? rd_elem : '0;
  assign out_last = out_valid && rd_end;

  // Input stage: element storage (data path, not reset)
  always_ff @(posedge clock) begin
    if (in_fire) begin
      bank_q[wr_bank][wr_row][wr_col] <= in_data;
    end
  end

  // Control: pointers, bank ownership, frame checking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q      <= '0;
      mode_q      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_row      <= '0;
      wr_col      <= '0;
      rd_row      <= '0;
      rd_col      <= '0;
      frame_error <= 1'b0;
    end else begin
      if (in_fire) begin
        if ((wr_row == '0) && (wr_col == '0)) begin
          mode_q[wr_bank] <= mode;
        end
        // in_last is advisory only; framing is purely positional.
        if (in_last != wr_end) begin
          frame_error <= 1'b1;
        end
        if (wr_col == LAST) begin
          wr_col <= '0;
          if (wr_row == LAST) begin
            wr_row          <= '0;
            wr_bank         <= ~wr_bank;
            full_q[wr_bank] <= 1'b1;
          end else begin
            wr_row <= wr_row + ONE;
          end
        end else begin
          wr_col <= wr_col + ONE;
        end
      end

      // A completing write targets an empty bank and a completing read a
      // full one, so the two full_q updates never collide.
      if (out_fire) begin
        if (rd_col == LAST) begin
          rd_col <= '0;
          if (rd_row == LAST) begin
            rd_row          <= '0;
            rd_bank         <= ~rd_bank;
            full_q[rd_bank] <= 1'b0;
          end else begin
            rd_row <= rd_row + ONE;
          end
        end else begin
          rd_col <= rd_col + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpu_stream_transpose.sv
module tb_mpu_stream_transpose;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_error;

  logic        c3_reset_n;
  logic        c3_mode;
  logic        c3_in_valid;
  logic        c3_in_ready;
  logic [15:0] c3_in_data;
  logic        c3_in_last;
  logic        c3_out_valid;
  logic        c3_out_ready;
  logic [15:0] c3_out_data;
  logic        c3_out_last;
  logic        c3_frame_error;

  int ntests = 0;
  int nfail  = 0;

  always #5 clock = ~clock;

  mpu_stream_transpose #(.N(5), .W(8)) dut (
    .clock(clock), .reset_n(reset_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_error(frame_error)
  );

  mpu_stream_transpose #(.N(3), .W(16)) dut3 (
    .clock(clock), .reset_n(c3_reset_n), .mode(c3_mode),
    .in_valid(c3_in_valid), .in_ready(c3_in_ready), .in_data(c3_in_data), .in_last(c3_in_last),
    .out_valid(c3_out_valid), .out_ready(c3_out_ready), .out_data(c3_out_data),
    .out_last(c3_out_last), .frame_error(c3_frame_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Streams nfr frames (bases b0,b1,b2) through the N=5 instance.
  // err_at: element index (0..24) of the first frame carrying a stray
  // in_last, or -1. hold: cycles with out_ready held low at the start.
  task automatic stream(input string name, input int nfr, input int b0, input int b1,
                        input int b2, input bit md, input int err_at, input int hold);
    int bases[3];
    int total, in_idx, out_idx, cyc, first_v, acc25, last_acc, err_cyc;
    int drops, gaps, holdbad, f, p, r, c, e;
    bases[0] = b0; bases[1] = b1; bases[2] = b2;
    total = nfr * 25;
    in_idx = 0; out_idx = 0; cyc = 0; first_v = -1; acc25 = -1; last_acc = -1;
    err_cyc = -1; drops = 0; gaps = 0; holdbad = 0;
    mode = md;
    while (out_idx < total && cyc < 600) begin
      @(negedge clock);
      if (err_cyc >= 0 && cyc == err_cyc + 1) chk({name, " ferr_rise"}, frame_error, 1);
      if (hold > 0 && last_acc >= 0 && cyc == last_acc + 1) chk({name, " stall_ready"}, in_ready, 0);
      out_ready = (cyc >= hold);
      if (out_valid && first_v < 0) first_v = cyc;
      if (first_v >= 0 && !out_valid) gaps++;
      if (!out_ready && out_valid && out_data !== 8'(bases[0] + 1)) holdbad++;
      if (out_valid && out_ready) begin
        f = out_idx / 25; p = out_idx % 25; r = p / 5; c = p % 5;
        e = md ? bases[f] + p + 1 : bases[f] + c * 5 + r + 1;
        chk($sformatf("%s data[%0d]", name, out_idx), out_data, e);
        chk($sformatf("%s last[%0d]", name, out_idx), out_last, (p == 24));
        out_idx++;
      end
      if (in_idx < total) begin
        f = in_idx / 25; p = in_idx % 25;
        in_valid = 1'b1;
        in_data  = 8'(bases[f] + p + 1);
        in_last  = (p == 24) || (f == 0 && p == err_at);
        if (!in_ready) begin
          drops++;
        end else begin
          if (f == 0 && p == err_at) begin
            chk({name, " ferr_before"}, frame_error, 0);
            err_cyc = cyc;
          end
          if (in_idx == 24) acc25 = cyc;
          if (in_idx == total - 1) last_acc = cyc;
          in_idx++;
        end
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      cyc++;
    end
    chk({name, " out_count"}, out_idx, total);
    chk({name, " latency"}, first_v, acc25 + 1);
    chk({name, " no_gaps"}, gaps, 0);
    if (hold == 0 && nfr > 1) chk({name, " ready_kept"}, drops, 0);
    if (hold > 0) chk({name, " stall_hold"}, holdbad, 0);
    chk({name, " ferr_end"}, frame_error, (err_at >= 0));
    @(negedge clock);
    in_valid = 1'b0;
    chk({name, " idle_valid"}, out_valid, 0);
    chk({name, " idle_ready"}, in_ready, 1);
  endtask

  initial begin
    int exp3[9];
    int ii, oi, cyc;
    exp3 = '{1, 4, 7, 2, 5, 8, 3, 6, 9};

    reset_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    c3_reset_n = 1'b0; c3_mode = 1'b0; c3_in_valid = 1'b0; c3_in_data = '0;
    c3_in_last = 1'b0; c3_out_ready = 1'b1;
    #2;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_last", out_last, 0);
    chk("rst frame_error", frame_error, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    c3_reset_n = 1'b1;

    stream("tr", 1, 0, 0, 0, 1'b0, -1, 0);
    stream("pass", 1, 0, 0, 0, 1'b1, -1, 0);
    stream("b2b", 3, 0, 100, 200, 1'b0, -1, 0);
    stream("stall", 2, 0, 100, 0, 1'b0, -1, 60);
    stream("err", 1, 0, 0, 0, 1'b0, 9, 0);

    // Partial frame abandoned by an asynchronous reset
    mode = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in_data = 8'(i + 50); in_last = 1'b0;
    end
    @(negedge clock);
    in_valid = 1'b0;
    chk("partial out_valid", out_valid, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst out_valid", out_valid, 0);
    chk("mid_rst in_ready", in_ready, 1);
    chk("mid_rst out_data", out_data, 0);
    chk("mid_rst frame_error", frame_error, 0);
    @(negedge clock);
    reset_n = 1'b1;
    stream("after_rst", 1, 0, 0, 0, 1'b0, -1, 0);

    // N=3, W=16: spec frame then one exercising the upper bits
    ii = 0; oi = 0; cyc = 0;
    while (oi < 18 && cyc < 100) begin
      @(negedge clock);
      c3_out_ready = 1'b1;
      if (c3_out_valid) begin
        chk($sformatf("n3 data[%0d]", oi), c3_out_data,
            ((oi >= 9) ? 32'hFF00 : 32'h0) + 32'(exp3[oi % 9]));
        chk($sformatf("n3 last[%0d]", oi), c3_out_last, ((oi % 9) == 8));
        oi++;
      end
      if (ii < 18) begin
        c3_in_valid = 1'b1;
        c3_in_data  = ((ii >= 9) ? 16'hFF00 : 16'h0) + 16'((ii % 9) + 1);
        c3_in_last  = ((ii % 9) == 8);
        if (c3_in_ready) ii++;
      end else begin
        c3_in_valid = 1'b0;
      end
      cyc++;
    end
    chk("n3 out_count", oi, 18);
    chk("n3 frame_error", c3_frame_error, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
